// File: rtl/doorlock_pkg.sv
// doorlock_pkg
//   Definitions shared by the keypad scanner, the PIN entry buffer and the
//   lock controller: key codes produced by the scanner and the PIN entry
//   state encoding.
//   No ports.
package doorlock_pkg;

  // Key codes 0-9 are the digits themselves.
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PRESENT
  } pin_state_t;

  function automatic logic key_is_digit(input logic [3:0] code);
    return code < KEY_A;
  endfunction

  function automatic logic key_is_letter(input logic [3:0] code);
    return (code == KEY_A) || (code == KEY_B) || (code == KEY_C) || (code == KEY_D);
  endfunction

endpackage

// File: rtl/pin_timeout_timer.sv
// pin_timeout_timer
//   Inactivity timer for a partial PIN entry. Counts up while run is high and
//   flags expire during the TIMEOUT_CYCLES-th running cycle after the last
//   clear, so the owner acts on the following clock edge.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   clear   in   restart the count (an accepted key)
//   run     in   count enable (entry being collected)
//   expire  out  high in the cycle whose closing edge completes the timeout
module pin_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  assign expire = run && (count == LAST);

  // Count stays at 0 whenever not running, so entering COLLECT always
  // starts from a fresh interval; it also restarts after expiring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !run || expire) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/pin_entry_buffer.sv
// pin_entry_buffer
//   Assembles a BCD PIN from keypad events and hands it to the lock
//   controller over a valid/ready handshake. Digits shift in (newest in the
//   low nibble), '*' deletes the newest digit, '#' submits, A-D are ignored.
//   A partial entry is discarded after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   enable        in   0 clears the buffer and forces IDLE
//   tecla_value   in   key code (0-9, A-D = 10-13, '*' = 14, '#' = 15)
//   tecla_valid   in   level, high while a debounced key is held
//   pin_data      out  BCD PIN, newest digit in [3:0]
//   pin_len       out  number of digits held
//   pin_valid     out  PIN offered to consumer
//   pin_ready     in   consumer accepts PIN
//   entry_active  out  digits held or PIN offered
//   key_beep      out  one-cycle pulse per accepted key
//   timeout       out  one-cycle pulse when a partial entry times out
module pin_entry_buffer
  import doorlock_pkg::*;
#(
  parameter int MAX_DIGITS     = 12,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [3:0]                           tecla_value,
  input  logic                                 tecla_valid,
  output logic [4*MAX_DIGITS-1:0]              pin_data,
  output logic [$clog2(MAX_DIGITS+1)-1:0]      pin_len,
  output logic                                 pin_valid,
  input  logic                                 pin_ready,
  output logic                                 entry_active,
  output logic                                 key_beep,
  output logic                                 timeout
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int LW = $clog2(MAX_DIGITS + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DIGITS);

  pin_state_t      state, state_n;
  logic            tecla_valid_q;
  logic            key_ev;
  logic            accept;
  logic            expire;
  logic [DW-1:0]   data_n;
  logic [LW-1:0]   len_n;
  logic            valid_n;
  logic            beep_n;
  logic            timeout_n;

  // Reset value of tecla_valid_q is 1 so a key held through reset is not
  // seen as a new press.
  assign key_ev = tecla_valid && !tecla_valid_q;

  assign entry_active = (pin_len != '0) || pin_valid;

  pin_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .run   (state == COLLECT),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tecla_valid_q <= 1'b1;
      pin_data      <= '0;
      pin_len       <= '0;
      pin_valid     <= 1'b0;
      key_beep      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_n;
      tecla_valid_q <= tecla_valid;
      pin_data      <= data_n;
      pin_len       <= len_n;
      pin_valid     <= valid_n;
      key_beep      <= beep_n;
      timeout       <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = pin_data;
    len_n     = pin_len;
    valid_n   = pin_valid;
    beep_n    = 1'b0;
    timeout_n = 1'b0;
    accept    = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      data_n  = '0;
      len_n   = '0;
      valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_ev && key_is_digit(tecla_value)) begin
            state_n = COLLECT;
            data_n  = {{(DW-4){1'b0}}, tecla_value};
            len_n   = LW'(1);
            beep_n  = 1'b1;
            accept  = 1'b1;
          end
        end

        COLLECT: begin
          // An accepted key takes priority over a simultaneous expiry.
          // A dropped digit or A-D is not accepted and lets the timer run.
          if (key_ev && key_is_digit(tecla_value) && (pin_len < MAX_LEN)) begin
            data_n = {pin_data[DW-5:0], tecla_value};
            len_n  = pin_len + LW'(1);
            beep_n = 1'b1;
            accept = 1'b1;
          end else if (key_ev && (tecla_value == KEY_STAR) && (pin_len != '0)) begin
            data_n = pin_data >> 4;
            len_n  = pin_len - LW'(1);
            beep_n = 1'b1;
            accept = 1'b1;
            if (pin_len == LW'(1)) begin
              state_n = IDLE;
            end
          end else if (key_ev && (tecla_value == KEY_HASH)) begin
            state_n = PRESENT;
            valid_n = 1'b1;
            beep_n  = 1'b1;
            accept  = 1'b1;
          end else if (expire) begin
            state_n   = IDLE;
            data_n    = '0;
            len_n     = '0;
            timeout_n = 1'b1;
          end
        end

        PRESENT: begin
          if (pin_valid && pin_ready) begin
            state_n = IDLE;
            data_n  = '0;
            len_n   = '0;
            valid_n = 1'b0;
          end
        end

        default: begin
          state_n = IDLE;
          data_n  = '0;
          len_n   = '0;
          valid_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_buffer.sv
// tb_pin_entry_buffer
//   Bench for pin_entry_buffer with MAX_DIGITS = 4, TIMEOUT_CYCLES = 20.
//   A queue-based reference model tracks the PIN and is compared with every
//   output after each clock; directed key tables and corner sequences sit on
//   top, followed by randomized key traffic.
module tb_pin_entry_buffer;

  localparam int MD = 4;
  localparam int TC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  tecla_value = 4'd0;
  logic        tecla_valid = 1'b0;
  logic        pin_ready = 1'b0;
  logic [15:0] pin_data;
  logic [2:0]  pin_len;
  logic        pin_valid;
  logic        entry_active;
  logic        key_beep;
  logic        timeout;

  always #5 clk = ~clk;

  pin_entry_buffer #(
    .MAX_DIGITS(MD),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tecla_value (tecla_value),
    .tecla_valid (tecla_valid),
    .pin_data    (pin_data),
    .pin_len     (pin_len),
    .pin_valid   (pin_valid),
    .pin_ready   (pin_ready),
    .entry_active(entry_active),
    .key_beep    (key_beep),
    .timeout     (timeout)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beeps = 0;

  // Reference model state: digits oldest first, presenting flag, idle count.
  int q[$];
  bit m_pres;
  int m_idle;
  bit m_prevv;
  bit m_beep;
  bit m_to;

  typedef struct {
    int          n;
    logic [23:0] keys;
    logic [15:0] data;
    logic [2:0]  len;
    logic        valid;
    int          nbeep;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_data();
    logic [15:0] d = '0;
    foreach (q[i]) d = {d[11:0], 4'(q[i])};
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pres  = 1'b0;
    m_idle  = 0;
    m_prevv = 1'b1;
    m_beep  = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    bit ev;
    bit acc;
    int k;
    ev      = tecla_valid && !m_prevv;
    m_prevv = tecla_valid;
    k       = int'(tecla_value);
    m_beep  = 1'b0;
    m_to    = 1'b0;
    acc     = 1'b0;
    if (!enable) begin
      q.delete();
      m_pres = 1'b0;
      m_idle = 0;
    end else if (m_pres) begin
      if (pin_ready) begin
        q.delete();
        m_pres = 1'b0;
      end
    end else begin
      if (ev) begin
        if (k < 10 && q.size() < MD) begin
          q.push_back(k);
          acc = 1'b1;
        end else if (k == 14 && q.size() > 0) begin
          void'(q.pop_back());
          acc = 1'b1;
        end else if (k == 15 && q.size() > 0) begin
          m_pres = 1'b1;
          acc = 1'b1;
        end
      end
      m_beep = acc;
      if (acc) begin
        m_idle = 0;
      end else if (q.size() > 0) begin
        m_idle++;
        if (m_idle == TC) begin
          q.delete();
          m_idle = 0;
          m_to = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    cyc++;
    if (key_beep) beeps++;
    if (!reset) begin
      chk("cycle_outputs",
          {pin_data, pin_len, pin_valid, key_beep, timeout, entry_active},
          {m_data(), 3'(q.size()), m_pres, m_beep, m_to, (q.size() != 0) || m_pres});
    end
  endtask

  task automatic rtick();
    pin_ready = ($urandom_range(0, 3) == 0);
    tick();
  endtask

  task automatic press(input logic [3:0] k);
    tecla_value = k;
    tecla_valid = 1'b1;
    repeat (5) tick();
    tecla_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic clear_all();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int c0;
    bit found;
    bit hold_ok;
    logic [23:0] kk;

    tbl[0] = '{5, 24'h1234F0, 16'h1234, 3'd4, 1'b1, 5};
    tbl[1] = '{5, 24'h12E5F0, 16'h0015, 3'd2, 1'b1, 5};
    tbl[2] = '{6, 24'h12345F, 16'h1234, 3'd4, 1'b1, 5};
    tbl[3] = '{2, 24'hFA0000, 16'h0000, 3'd0, 1'b0, 0};
    tbl[4] = '{4, 24'h1EEF00, 16'h0000, 3'd0, 1'b0, 2};
    tbl[5] = '{4, 24'h9B3F00, 16'h0093, 3'd2, 1'b1, 3};

    model_reset();
    #2;
    chk("reset_state", {pin_data, pin_len, pin_valid, key_beep, timeout, entry_active}, 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Directed key tables
    for (int s = 0; s < 6; s++) begin
      clear_all();
      b0 = beeps;
      kk = tbl[s].keys;
      for (int i = 0; i < tbl[s].n; i++) press(kk[23-4*i -: 4]);
      chk("table_data", pin_data, tbl[s].data);
      chk("table_len", pin_len, tbl[s].len);
      chk("table_valid", pin_valid, tbl[s].valid);
      chk("table_beeps", beeps - b0, tbl[s].nbeep);
      if (tbl[s].valid) begin
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (!pin_valid || pin_data != tbl[s].data) hold_ok = 1'b0;
        end
        chk("valid_hold10", hold_ok, 1);
        pin_ready = 1'b1;
        tick();
        pin_ready = 1'b0;
        chk("handshake_clear", {pin_valid, pin_len, pin_data}, 0);
      end
    end

    // Timeout after a single digit
    clear_all();
    tecla_value = 4'd7;
    tecla_valid = 1'b1;
    tick();
    chk("accept_beep", key_beep, 1);
    c0 = cyc;
    repeat (4) tick();
    tecla_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (timeout) found = 1'b1;
    end
    chk("timeout_delay", cyc - c0, TC);
    chk("timeout_len", pin_len, 0);
    chk("timeout_active", entry_active, 0);

    // Key event in the expiry cycle wins over the timeout
    tecla_value = 4'd7;
    tecla_valid = 1'b1;
    tick();
    c0 = cyc;
    repeat (4) tick();
    tecla_valid = 1'b0;
    while (cyc < c0 + TC - 1) tick();
    tecla_value = 4'd3;
    tecla_valid = 1'b1;
    tick();
    chk("key_wins_timeout", timeout, 0);
    chk("key_wins_beep", key_beep, 1);
    chk("key_wins_len", pin_len, 2);
    repeat (4) tick();
    tecla_valid = 1'b0;
    tick();
    chk("key_wins_data", pin_data, 16'h0073);

    // Key held across reset release
    tecla_value = 4'd5;
    tecla_valid = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    b0 = beeps;
    repeat (5) tick();
    chk("held_reset_beeps", beeps - b0, 0);
    chk("held_reset_len", pin_len, 0);
    tecla_valid = 1'b0;
    tick();
    press(4'd5);
    chk("after_release_len", pin_len, 1);
    clear_all();

    // Keys pressed while presenting are ignored, then enable drop
    press(4'd1);
    press(4'd2);
    press(4'hF);
    b0 = beeps;
    press(4'd7);
    press(4'hE);
    press(4'hF);
    chk("present_ignore", {pin_valid, pin_len, pin_data}, {1'b1, 3'd2, 16'h0012});
    chk("present_beeps", beeps - b0, 0);
    enable = 1'b0;
    tick();
    chk("enable_drop", {pin_valid, pin_len, pin_data, key_beep, timeout}, 0);
    enable = 1'b1;
    tick();

    // Asynchronous reset while presenting
    press(4'd4);
    press(4'hF);
    chk("pre_reset_valid", pin_valid, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset", {pin_valid, pin_len, pin_data, entry_active}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        enable = 1'b0;
        rtick();
        enable = 1'b1;
      end else if (r < 10) begin
        repeat (25) rtick();
      end else begin
        if ($urandom_range(0, 1) == 1) tecla_value = 4'($urandom_range(0, 9));
        else tecla_value = 4'($urandom_range(10, 15));
        tecla_valid = 1'b1;
        repeat ($urandom_range(1, 6)) rtick();
        tecla_valid = 1'b0;
        repeat ($urandom_range(0, 3)) rtick();
      end
    end
    pin_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
